// File: rtl/cordic_pkg.sv
// Shared definitions for the iterative CORDIC sequencer: datapath widths, arctangent
// table, inverse-gain constant and the controller state encoding.
package cordic_pkg;

    localparam int XY_W = 18;
    localparam int Z_W  = 15;

    // round(atan(2^-i) * 2^14 / pi); one z LSB is pi/2^14
    localparam logic [Z_W-1:0] ATAN [16] = '{
        15'd4096, 15'd2418, 15'd1278, 15'd649, 15'd326, 15'd163, 15'd81, 15'd41,
        15'd20,   15'd10,   15'd5,    15'd3,   15'd1,   15'd1,   15'd0,  15'd0
    };

    localparam logic [XY_W-1:0] K_INV = 18'd19898;  // 0.60725 in Q1.15

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // v * K_INV, arithmetic-shifted right by 15 and truncated back to XY_W bits
    function automatic logic [XY_W-1:0] gain_comp(input logic [XY_W-1:0] v);
        logic signed [2*XY_W-1:0] prod;
        prod = $signed(v) * $signed(K_INV);
        return XY_W'(prod >>> 15);
    endfunction

endpackage

// File: rtl/cordic_iter.sv
// One CORDIC micro-rotation, purely combinational, with a runtime shift amount.
// All arithmetic wraps in two's complement at the port widths.
module cordic_iter
    import cordic_pkg::*;
(
    input  logic            mode,
    input  logic [XY_W-1:0] x_in,
    input  logic [XY_W-1:0] y_in,
    input  logic [Z_W-1:0]  z_in,
    input  logic [3:0]      shift,
    input  logic [Z_W-1:0]  atan_c,
    output logic [XY_W-1:0] x_out,
    output logic [XY_W-1:0] y_out,
    output logic [Z_W-1:0]  z_out
);

    logic            d;
    logic [XY_W-1:0] xs;
    logic [XY_W-1:0] ys;

    always_comb begin
        // rotating steers z toward zero, vectoring steers y toward zero
        d     = mode ? z_in[Z_W-1] : y_in[XY_W-1];
        xs    = XY_W'($signed(y_in) >>> shift);
        ys    = XY_W'($signed(x_in) >>> shift);
        x_out = d ? x_in - xs : x_in + xs;
        y_out = d ? y_in + ys : y_in - ys;
        z_out = d ? z_in + atan_c : z_in - atan_c;
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Iterative CORDIC sequencer: one shared micro-rotation reused for ITER cycles per job.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle SCALE state that removes the CORDIC gain.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int ITER  = 14,
    parameter int CNT_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mode,
    input  logic [XY_W-1:0] in_x,
    input  logic [XY_W-1:0] in_y,
    input  logic [Z_W-1:0]  in_z,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XY_W-1:0] out_x,
    output logic [XY_W-1:0] out_y,
    output logic [Z_W-1:0]  out_z,
    output logic            busy
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XY_W-1:0]  x_q, x_d;
    logic [XY_W-1:0]  y_q, y_d;
    logic [Z_W-1:0]   z_q, z_d;
    logic             mode_q, mode_d;

    logic [3:0]       idx;
    logic [XY_W-1:0]  x_rot, y_rot;
    logic [Z_W-1:0]   z_rot;

    assign idx = 4'(cnt_q);

    cordic_iter u_iter (
        .mode   (mode_q),
        .x_in   (x_q),
        .y_in   (y_q),
        .z_in   (z_q),
        .shift  (idx),
        .atan_c (ATAN[idx]),
        .x_out  (x_rot),
        .y_out  (y_rot),
        .z_out  (z_rot)
    );

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_x;
                    y_d     = in_y;
                    z_d     = in_z;
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d   = x_rot;
                y_d   = y_rot;
                z_d   = z_rot;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(ITER - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_d = SCALE;
`else
                    state_d = DONE;
`endif
                end
            end
`ifdef CORDIC_GAIN_COMP_EN
            SCALE: begin
                x_d     = gain_comp(x_q);
                y_d     = gain_comp(y_q);
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an aborted job leaves zeros, not residue.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == SCALE);
    assign out_valid = (state_q == DONE);
    assign out_x     = x_q;
    assign out_y     = y_q;
    assign out_z     = z_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Self-checking bench for cordic_iter_ctrl: an ITER=2 and an ITER=14 instance checked
// every cycle against a job-level arithmetic model, plus hand-computed literals.
module tb_cordic_iter_ctrl;

    localparam int N = 2;
    localparam int ITERS [N] = '{2, 14};
`ifdef CORDIC_GAIN_COMP_EN
    localparam bit GAIN = 1'b1;
`else
    localparam bit GAIN = 1'b0;
`endif
    localparam int ATAN_TAB [16] = '{4096, 2418, 1278, 649, 326, 163, 81, 41,
                                     20, 10, 5, 3, 1, 1, 0, 0};

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        in_valid  [N];
    logic        in_ready  [N];
    logic        in_mode   [N];
    logic [17:0] in_x      [N];
    logic [17:0] in_y      [N];
    logic [14:0] in_z      [N];
    logic        out_valid [N];
    logic        out_ready [N];
    logic [17:0] out_x     [N];
    logic [17:0] out_y     [N];
    logic [14:0] out_z     [N];
    logic        busy      [N];

    cordic_iter_ctrl #(.ITER(ITERS[0]), .CNT_W(4)) u_dut_i2 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_mode(in_mode[0]),
        .in_x(in_x[0]), .in_y(in_y[0]), .in_z(in_z[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_x(out_x[0]), .out_y(out_y[0]), .out_z(out_z[0]), .busy(busy[0])
    );

    cordic_iter_ctrl #(.ITER(ITERS[1]), .CNT_W(4)) u_dut_i14 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_mode(in_mode[1]),
        .in_x(in_x[1]), .in_y(in_y[1]), .in_z(in_z[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_x(out_x[1]), .out_y(out_y[1]), .out_z(out_z[1]), .busy(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sx18(input logic [17:0] v);
        return int'($signed(v));
    endfunction

    function automatic int sx15(input logic [14:0] v);
        return int'($signed(v));
    endfunction

    // sign-wrap v into a w-bit two's complement value
    function automatic int wrap(input longint v, input int w);
        longint s;
        s = v <<< (64 - w);
        s = s >>> (64 - w);
        return int'(s);
    endfunction

    typedef struct {
        int x;
        int y;
        int z;
    } res_t;

    // whole-job reference: iterate the CORDIC recurrence on plain integers
    function automatic res_t cordic_model(input int x0, input int y0, input int z0,
                                          input bit rot, input int iter, input bit scale);
        res_t r;
        int x, y, z, xs, ys;
        bit d;
        x = wrap(x0, 18);
        y = wrap(y0, 18);
        z = wrap(z0, 15);
        for (int i = 0; i < iter; i++) begin
            d  = rot ? (z < 0) : (y < 0);
            xs = y >>> i;
            ys = x >>> i;
            if (d) begin
                x = wrap(longint'(x) - xs, 18);
                y = wrap(longint'(y) + ys, 18);
                z = wrap(longint'(z) + ATAN_TAB[i], 15);
            end else begin
                x = wrap(longint'(x) + xs, 18);
                y = wrap(longint'(y) - ys, 18);
                z = wrap(longint'(z) - ATAN_TAB[i], 15);
            end
        end
        if (scale) begin
            x = wrap((longint'(x) * 19898) >>> 15, 18);
            y = wrap((longint'(y) * 19898) >>> 15, 18);
        end
        r.x = x;
        r.y = y;
        r.z = z;
        return r;
    endfunction

    // job-level model: 0 idle, 1 working, 2 result held
    int   m_phase [N] = '{0, 0};
    int   m_left  [N] = '{0, 0};
    res_t m_pend  [N];
    res_t m_out   [N];

    always @(posedge clock or posedge reset) begin
        for (int u = 0; u < N; u++) begin
            if (reset) begin
                m_phase[u] = 0;
                m_left[u]  = 0;
                m_out[u]   = '{0, 0, 0};
            end else begin
                case (m_phase[u])
                    0: if (in_valid[u] === 1'b1) begin
                        m_pend[u]  = cordic_model(sx18(in_x[u]), sx18(in_y[u]), sx15(in_z[u]),
                                                  in_mode[u], ITERS[u], GAIN);
                        m_left[u]  = ITERS[u] + int'(GAIN);
                        m_phase[u] = 1;
                    end
                    1: begin
                        m_left[u]--;
                        if (m_left[u] == 0) begin
                            m_phase[u] = 2;
                            m_out[u]   = m_pend[u];
                        end
                    end
                    default: if (out_ready[u] === 1'b1) m_phase[u] = 0;
                endcase
            end
        end
    end

    // per-cycle comparison against the model, away from the active edge
    always @(negedge clock) begin
        for (int u = 0; u < N; u++) begin
            check($sformatf("i%0d in_ready", ITERS[u]), in_ready[u], m_phase[u] == 0);
            check($sformatf("i%0d busy", ITERS[u]), busy[u], m_phase[u] == 1);
            check($sformatf("i%0d out_valid", ITERS[u]), out_valid[u], m_phase[u] == 2);
            if (m_phase[u] != 1) begin
                check($sformatf("i%0d out_x", ITERS[u]), sx18(out_x[u]), m_out[u].x);
                check($sformatf("i%0d out_y", ITERS[u]), sx18(out_y[u]), m_out[u].y);
                check($sformatf("i%0d out_z", ITERS[u]), sx15(out_z[u]), m_out[u].z);
            end
        end
    end

    // called away from the rising edge; returns at the falling edge after acceptance
    task automatic send(input int u, input bit mode, input int x, input int y, input int z);
        int guard;
        guard       = 0;
        in_mode[u]  = mode;
        in_x[u]     = 18'(x);
        in_y[u]     = 18'(y);
        in_z[u]     = 15'(z);
        in_valid[u] = 1'b1;
        while (in_ready[u] !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check($sformatf("i%0d accepted within bound", ITERS[u]), guard < 100, 1);
        @(negedge clock);
        in_valid[u] = 1'b0;
    endtask

    // edges counted include the accepting edge itself
    task automatic wait_valid(input int u);
        int edges;
        edges = 0;
        while (out_valid[u] !== 1'b1 && edges < 200) begin
            @(negedge clock);
            edges++;
        end
        check($sformatf("i%0d latency edges incl accept", ITERS[u]), edges + 1,
              ITERS[u] + int'(GAIN) + 1);
    endtask

    task automatic run_job(input int u, input bit mode, input int x, input int y, input int z,
                           output int ox, output int oy, output int oz);
        out_ready[u] = 1'b1;
        send(u, mode, x, y, z);
        wait_valid(u);
        ox = sx18(out_x[u]);
        oy = sx18(out_y[u]);
        oz = sx15(out_z[u]);
        @(negedge clock);
    endtask

    typedef struct {
        int u;
        bit mode;
        int x;
        int y;
        int z;
    } vec_t;

    vec_t vecs [6] = '{
        '{0, 1'b1, -16384, 5000, 8000},
        '{1, 1'b1, 30000, -20000, -12000},
        '{1, 1'b0, 131071, 131071, 0},
        '{1, 1'b0, -60000, -25000, 100},
        '{0, 1'b0, -131072, 0, -16384},
        '{1, 1'b1, 1000, 2000, 16383}
    };

`ifdef CORDIC_GAIN_COMP_EN
    localparam int E_ROT_X = 14923, E_ROT_Y = -4975, E_VEC_X = 9108, E_VEC_Y = -3037;
`else
    localparam int E_ROT_X = 24576, E_ROT_Y = -8192, E_VEC_X = 15000, E_VEC_Y = -5000;
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int ox, oy, oz;
        for (int u = 0; u < N; u++) begin
            in_valid[u]  = 1'b0;
            in_mode[u]   = 1'b0;
            in_x[u]      = '0;
            in_y[u]      = '0;
            in_z[u]      = '0;
            out_ready[u] = 1'b1;
        end

        // reset state
        repeat (2) @(negedge clock);
        for (int u = 0; u < N; u++) begin
            check("reset in_ready", in_ready[u], 1);
            check("reset out_valid", out_valid[u], 0);
            check("reset busy", busy[u], 0);
            check("reset out_x", sx18(out_x[u]), 0);
        end
        reset = 1'b0;
        @(negedge clock);
        check("post-reset in_ready", in_ready[0], 1);

        // pin the model against hand-derived values
        r = cordic_model(16384, 0, 0, 1'b1, 2, 1'b0);
        check("model rot2 x", r.x, 24576);
        check("model rot2 y", r.y, -8192);
        check("model rot2 z", r.z, -1678);
        r = cordic_model(10000, 0, 0, 1'b0, 1, 1'b0);
        check("model vec iter0 x", r.x, 10000);
        check("model vec iter0 y", r.y, -10000);
        check("model vec iter0 z", r.z, -4096);
        r = cordic_model(10000, 0, 0, 1'b0, 2, 1'b0);
        check("model vec2 x", r.x, 15000);
        check("model vec2 y", r.y, -5000);
        check("model vec2 z", r.z, -1678);
        r = cordic_model(15000, -5000, 0, 1'b0, 0, 1'b1);
        check("model scale x", r.x, 9108);
        check("model scale y", r.y, -3037);

        // ITER=2 rotating and vectoring against literals
        run_job(0, 1'b1, 16384, 0, 0, ox, oy, oz);
        check("i2 rot out_x", ox, E_ROT_X);
        check("i2 rot out_y", oy, E_ROT_Y);
        check("i2 rot out_z", oz, -1678);
        run_job(0, 1'b0, 10000, 0, 0, ox, oy, oz);
        check("i2 vec out_x", ox, E_VEC_X);
        check("i2 vec out_y", oy, E_VEC_Y);
        check("i2 vec out_z", oz, -1678);

        // ITER=14 vectoring toward the 45 degree angle
        run_job(1, 1'b0, 10000, 10000, 0, ox, oy, oz);
        check("i14 vec z within 3 of -4096", (oz >= -4099) && (oz <= -4093), 1);
        check("i14 vec y within 2 of 0", (oy >= -2) && (oy <= 2), 1);
        check("i14 vec out_z", oz, -4096);
        check("i14 vec out_y", oy, 0);
`ifndef CORDIC_GAIN_COMP_EN
        check("i14 vec out_x", ox, 23290);
`endif

        // directed vectors including extreme inputs and wrap-around
        foreach (vecs[k]) begin
            r = cordic_model(vecs[k].x, vecs[k].y, vecs[k].z, vecs[k].mode,
                             ITERS[vecs[k].u], GAIN);
            run_job(vecs[k].u, vecs[k].mode, vecs[k].x, vecs[k].y, vecs[k].z, ox, oy, oz);
            check($sformatf("vec%0d out_x", k), ox, r.x);
            check($sformatf("vec%0d out_y", k), oy, r.y);
            check($sformatf("vec%0d out_z", k), oz, r.z);
        end

        // back-pressure: result held for 10 cycles, a stray offer is ignored
        r = cordic_model(-20000, 7000, 0, 1'b0, ITERS[0], GAIN);
        out_ready[0] = 1'b0;
        send(0, 1'b0, -20000, 7000, 0);
        wait_valid(0);
        for (int k = 0; k < 10; k++) begin
            check("bp out_valid", out_valid[0], 1);
            check("bp in_ready", in_ready[0], 0);
            check("bp out_x", sx18(out_x[0]), r.x);
            check("bp out_y", sx18(out_y[0]), r.y);
            check("bp out_z", sx15(out_z[0]), r.z);
            if (k == 3) begin
                in_mode[0]  = 1'b1;
                in_x[0]     = 18'd5;
                in_valid[0] = 1'b1;
            end
            if (k == 4) in_valid[0] = 1'b0;
            @(negedge clock);
        end
        out_ready[0] = 1'b1;
        @(negedge clock);
        check("bp release in_ready", in_ready[0], 1);
        check("bp release out_valid", out_valid[0], 0);
        check("bp retained out_x", sx18(out_x[0]), r.x);

        // asynchronous reset in the middle of a job
        r = cordic_model(12345, -6789, 0, 1'b0, ITERS[1], GAIN);
        send(1, 1'b0, 12345, -6789, 0);
        repeat (5) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check("midreset out_valid", out_valid[1], 0);
        check("midreset busy", busy[1], 0);
        check("midreset out_x", sx18(out_x[1]), 0);
        check("midreset out_y", sx18(out_y[1]), 0);
        check("midreset out_z", sx15(out_z[1]), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("after reset in_ready", in_ready[1], 1);
        run_job(1, 1'b0, 12345, -6789, 0, ox, oy, oz);
        check("after reset out_x", ox, r.x);
        check("after reset out_y", oy, r.y);
        check("after reset out_z", oz, r.z);

`ifdef CORDIC_GAIN_COMP_EN
        // gain-compensated rotation of a unit vector returns close to its input
        run_job(1, 1'b1, 16384, 0, 0, ox, oy, oz);
        check("gain x within 4 of 16384", (ox >= 16380) && (ox <= 16388), 1);
        check("gain y within 4 of 0", (oy >= -4) && (oy <= 4), 1);
`endif

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cordic_iter_ctrl.md
Name: cordic_iter_ctrl

Overview:
- Iterative CORDIC sequencer: one shared micro-rotation datapath, reused over ITER clock cycles instead of an unrolled chain of fixed-shift stages.
- Accepts one (x, y, z, mode) job through a valid/ready handshake and steps the shift index and arctangent constant each cycle.
- Presents the result through a valid/ready handshake.
- Sits between the AVS sample front-end and the angle/magnitude consumers.

Parameters:
- ITER, 14, number of micro-rotations per job; legal range 1..16
- CNT_W, 4, iteration counter width; must satisfy 2^CNT_W >= ITER

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  job offered
- in_ready  out  1  block can accept a job
- in_mode  in  1  1 = rotating (direction from z sign), 0 = vectoring (direction from y sign)
- in_x  in  18  signed x
- in_y  in  18  signed y
- in_z  in  15  signed angle; LSB = pi/2^14
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_x  out  18  signed x result
- out_y  out  18  signed y result
- out_z  out  15  signed z result
- busy  out  1  high in RUN (and SCALE)

Behaviour:
- Reset is asynchronous, active-high, and may arrive at any time, including mid-job. On reset:
  - state = IDLE, counter = 0, x/y/z registers = 0, mode = 0.
  - out_valid = 0, busy = 0, in_ready = 1 on the first cycle after reset deasserts.
  - Any in-flight job is dropped.
- States: IDLE, RUN, DONE (plus SCALE when GAIN_COMP_EN is defined).
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch x, y, z, mode; counter = 0; go to RUN.
- RUN:
  - in_ready = 0, busy = 1.
  - Each cycle applies iteration i = counter:
    - d = mode ? z[14] : y[17].
    - xs = y >>> i, ys = x >>> i (arithmetic shifts).
    - x' = d ? x - xs : x + xs.
    - y' = d ? y + ys : y - ys.
    - z' = d ? z + ATAN[i] : z - ATAN[i].
  - All arithmetic is 18-bit (x, y) or 15-bit (z) two's complement, wrapping on overflow with no saturation.
  - counter increments each cycle. After the cycle with i = ITER-1, go to DONE (or SCALE).
- Latency: exactly ITER+1 clock edges from the accepting edge to out_valid = 1 without the optional feature.
- DONE:
  - out_valid = 1; out_x/y/z hold the final values and stay stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid = 0 next cycle.
  - in_ready = 0 in DONE, so a job cannot be accepted on the same edge the result is consumed. Back-to-back throughput is one job per ITER+2 cycles.
- in_valid while busy is ignored; the offering side must hold the job until in_ready.
- out_x/y/z are registered and retain their last value in IDLE.
- ATAN[i] = round(atan(2^-i) * 2^14 / pi), giving 4096, 2418, 1278, 649, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0, 0.

Optional Feature:
- Macro: CORDIC_GAIN_COMP_EN.
- Defined:
  - Adds state SCALE between RUN and DONE, lasting one cycle.
  - x and y are each multiplied by K_INV = 19898 (Q1.15, 0.60725), then arithmetic-shifted right by 15 and truncated to 18 bits.
  - z is unchanged. Latency becomes ITER+2.
- Undefined: no SCALE state; outputs carry the CORDIC gain of about 1.647.

Decomposition:
- Package cordic_pkg holds:
  - width constants XY_W = 18, Z_W = 15;
  - ATAN lookup table of 16 entries, 15-bit;
  - K_INV;
  - state encoding IDLE/RUN/SCALE/DONE.
- Sub-module cordic_iter: purely combinational single micro-rotation with a runtime shift input (x, y, z, mode, shift, constant → x', y', z'). The controller owns all state and registers.

Test Plan:
- ITER=2, rotating, x=16384, y=0, z=0, out_ready=1 -> out_x=24576, out_y=-8192, out_z=-1678, out_valid on the third edge after acceptance.
- ITER=2, vectoring, x=10000, y=0, z=0 -> iteration 0 gives x=10000, y=-10000, z=-4096; iteration 1 gives out_x=15000, out_y=-5000, out_z=-1678.
- ITER=14, vectoring, x=10000, y=10000, z=0 -> out_z within ±3 LSB of -4096 and out_y within ±2 of 0; must match a bit-accurate model exactly.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and outputs stable, in_ready=0, and an in_valid pulse is ignored; then out_ready=1 -> IDLE, in_ready=1 the next cycle.
- Reset asserted on RUN cycle 5 -> immediately out_valid=0, busy=0, registers 0; a new job after release completes with correct values.
- CORDIC_GAIN_COMP_EN defined, ITER=14, rotating, x=16384, y=0, z=0 -> out_x within ±4 of 16384, out_y within ±4 of 0, latency ITER+2.
